fft_cfg_seq: RTL

- Configuration source for the staged FFT datapath: accepts a transform request (size, scaling mode) over a valid/ready handshake.
- Decodes the request into the per-stage select and scaling vectors that feed the per-stage delay alignment.
- Sequences a safe switchover: stalls upstream, drains in-flight data, then applies the new vectors atomically and pulses an update strobe.

---
 rtl/fft_cfg_pkg.sv | 25 ++
 rtl/fft_cfg_if.sv | 32 +++
 rtl/fft_cfg_decode.sv | 38 +++
 rtl/fft_cfg_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fft_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Package : fft_cfg_pkg
// Brief   : Shared constants and enums for the FFT configuration sequencer.
// Rev     : 1.0
// ============================================================================
package fft_cfg_pkg;

    localparam int MAX_LOG2 = 13;

    typedef enum logic [1:0] {
        SC_NONE    = 2'd0,
        SC_UNIFORM = 2'd1,
        SC_ALT     = 2'd2,
        SC_RSVD    = 2'd3
    } scale_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } state_e;

endpackage : fft_cfg_pkg
`default_nettype wire

// File: rtl/fft_cfg_if.sv
`default_nettype none
// ============================================================================
// Interface : fft_cfg_if
// Brief     : Transform-request valid/ready channel into the config sequencer.
// Rev       : 1.0
// ============================================================================
interface fft_cfg_if;

    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_log2n;
    logic [1:0] cfg_scale_mode;
    logic [1:0] cfg_scale_val;

    modport master (
        output cfg_valid,
        output cfg_log2n,
        output cfg_scale_mode,
        output cfg_scale_val,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_log2n,
        input  cfg_scale_mode,
        input  cfg_scale_val,
        output cfg_ready
    );

endinterface : fft_cfg_if
`default_nettype wire

// File: rtl/fft_cfg_decode.sv
`default_nettype none
// ============================================================================
// Module : fft_cfg_decode
// Brief  : Combinational decode of a transform request into stage vectors.
// Rev    : 1.0
// ============================================================================
module fft_cfg_decode #(
    parameter int MAX_LOG2 = fft_cfg_pkg::MAX_LOG2
) (
    input  wire logic [3:0]            log2n,
    input  wire logic [1:0]            mode,
    input  wire logic [1:0]            val,
    output logic      [MAX_LOG2-1:0]   select,
    output logic      [2*MAX_LOG2-1:0] scaling,
    output logic                       legal
);
    import fft_cfg_pkg::*;

    scale_mode_e w_mode;

    assign w_mode = scale_mode_e'(mode);

    assign legal = (log2n != 4'd0) && (int'(log2n) <= MAX_LOG2) && (w_mode != SC_RSVD);

    for (genvar k = 0; k < MAX_LOG2; k++) begin : g_stage
        localparam bit c_even = ((k % 2) == 0);

        assign select[k] = (int'(log2n) > k);

        // Disabled stages are forced to zero shift regardless of mode.
        assign scaling[2*k+1:2*k] = !select[k]                     ? 2'b00 :
                                    (w_mode == SC_UNIFORM)          ? val   :
                                    ((w_mode == SC_ALT) && c_even)  ? 2'b01 :
                                                                      2'b00;
    end : g_stage

endmodule : fft_cfg_decode
`default_nettype wire

// File: rtl/fft_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module : fft_cfg_seq
// Brief  : Accepts FFT config requests, drains the datapath, applies atomically.
// Rev    : 1.0
// ============================================================================
module fft_cfg_seq #(
    parameter int MAX_LOG2  = fft_cfg_pkg::MAX_LOG2,
    parameter int DRAIN_CYC = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    fft_cfg_if.slave                        cfg,
    input  wire logic                       in_valid,
    input  wire logic                       in_flight,
    output logic                            hold_in,
    output logic      [MAX_LOG2-1:0]        select,
    output logic      [2*MAX_LOG2-1:0]      scaling,
    output logic                            cfg_update,
    output logic                            cfg_err,
    output logic                            proto_err
);
    import fft_cfg_pkg::*;

    localparam int                 c_cnt_w      = $clog2(DRAIN_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_reload = c_cnt_w'(DRAIN_CYC - 1);

    state_e                  r_state;
    state_e                  w_state_next;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_cnt_w-1:0]      w_cnt_next;
    logic [MAX_LOG2-1:0]     r_shadow_sel;
    logic [2*MAX_LOG2-1:0]   r_shadow_scl;
    logic [MAX_LOG2-1:0]     r_select;
    logic [2*MAX_LOG2-1:0]   r_scaling;
    logic                    r_cfg_update;
    logic                    r_cfg_err;
    logic                    r_proto_err;

    logic                    w_ready;
    logic                    w_hs;
    logic                    w_load;
    logic                    w_apply;
    logic                    w_err_next;
    logic                    w_proto_next;
    logic [MAX_LOG2-1:0]     w_dec_sel;
    logic [2*MAX_LOG2-1:0]   w_dec_scl;
    logic                    w_dec_legal;

    fft_cfg_decode #(
        .MAX_LOG2 (MAX_LOG2)
    ) u_decode (
        .log2n   (cfg.cfg_log2n),
        .mode    (cfg.cfg_scale_mode),
        .val     (cfg.cfg_scale_val),
        .select  (w_dec_sel),
        .scaling (w_dec_scl),
        .legal   (w_dec_legal)
    );

    // Ready is masked by reset so no request can be accepted while held.
    assign w_ready       = (r_state == IDLE) && !rst;
    assign w_hs          = cfg.cfg_valid && w_ready;
    assign cfg.cfg_ready = w_ready;
    assign hold_in       = (r_state != IDLE);
    assign select        = r_select;
    assign scaling       = r_scaling;
    assign cfg_update    = r_cfg_update;
    assign cfg_err       = r_cfg_err;
    assign proto_err     = r_proto_err;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_apply      = 1'b0;
        w_err_next   = 1'b0;
        w_proto_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    if (w_dec_legal) begin
                        w_load       = 1'b1;
                        w_cnt_next   = c_cnt_reload;
                        w_state_next = DRAIN;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // A beat arriving mid-drain restarts the full drain window.
                if (in_valid) begin
                    w_cnt_next   = c_cnt_reload;
                    w_proto_next = 1'b1;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if (!in_flight) begin
                    w_state_next = APPLY;
                end
            end
            APPLY: begin
                w_apply      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shadow_sel <= '0;
            r_shadow_scl <= '0;
            r_select     <= '0;
            r_scaling    <= '0;
            r_cfg_update <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_cfg_update <= w_apply;
            r_cfg_err    <= w_err_next;
            r_proto_err  <= w_proto_next;
            if (w_load) begin
                r_shadow_sel <= w_dec_sel;
                r_shadow_scl <= w_dec_scl;
            end
            if (w_apply) begin
                r_select  <= r_shadow_sel;
                r_scaling <= r_shadow_scl;
            end
        end
    end

endmodule : fft_cfg_seq
`default_nettype wire
